// File: rtl/fir_sym_pipe_if.sv
// Sample, coefficient-write and result signals of the symmetric FIR.
// master drives samples and coefficients; slave is the filter.
interface fir_sym_pipe_if #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 3
);
    logic                 clr;
    logic                 in_valid;
    logic signed [DW-1:0] x;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 out_valid;
    logic signed [DW-1:0] y;
    logic                 sat;

    modport master (
        output clr, in_valid, x, coef_we, coef_addr, coef_wdata,
        input  out_valid, y, sat
    );

    modport slave (
        input  clr, in_valid, x, coef_we, coef_addr, coef_wdata,
        output out_valid, y, sat
    );
endinterface

// File: rtl/fir_sym_pipe.sv
// Symmetric odd-length FIR: pre-add, multiply, sum, then round/shift/saturate.
// Latency: sample accepted on edge k gives out_valid after edge k+4; one sample per clock.
// No backpressure: the consumer must take y on the out_valid cycle.
module fir_sym_pipe #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int NTAPS = 9,
    parameter int SHIFT = 0,
    parameter logic [((NTAPS+1)/2)*CW-1:0] RST_COEF =
        {16'hfffe, 16'h0000, 16'h0006, 16'h0012, 16'h0020}
) (
    input logic           clk,
    input logic           rstN,
    fir_sym_pipe_if.slave bus
);
    localparam int NU   = (NTAPS + 1) / 2;
    localparam int PW   = DW + 1;
    localparam int MW   = DW + CW + 1;
    localparam int ACCW = MW + $clog2(NU);
    localparam int RW   = ACCW + 1;
    localparam logic signed [RW-1:0] RND  = RW'((1 << SHIFT) >> 1);
    localparam logic signed [RW-1:0] YMAX = RW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] YMIN = -YMAX - RW'(1);

    logic signed [DW-1:0]   d [NTAPS];
    logic                   dv;
    logic signed [CW-1:0]   c [NU];
    logic signed [PW-1:0]   p [NU];
    logic signed [MW-1:0]   m [NU];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [RW-1:0]   r;
    logic                   v1, v2, v3;
    logic                   ov_q, sat_q;
    logic signed [DW-1:0]   y_q;

    // dv marks that the delay line took a sample on the previous edge
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < NTAPS; k++) d[k] <= '0;
            dv <= 1'b0;
        end else if (bus.clr) begin
            for (int k = 0; k < NTAPS; k++) d[k] <= '0;
            dv <= 1'b0;
        end else begin
            dv <= bus.in_valid;
            if (bus.in_valid) begin
                d[0] <= bus.x;
                for (int k = 1; k < NTAPS; k++) d[k] <= d[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NU; i++) c[i] <= RST_COEF[i*CW +: CW];
        end else if (bus.coef_we && (32'(bus.coef_addr) < NU)) begin
            c[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < NU; i++) acc_sum = acc_sum + ACCW'(m[i]);
    end

    // data stages run every cycle; only the valid bits qualify them
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NU; i++) begin
                p[i] <= '0;
                m[i] <= '0;
            end
            acc <= '0;
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
        end else begin
            for (int i = 0; i < NU - 1; i++) p[i] <= PW'(d[i]) + PW'(d[NTAPS-1-i]);
            p[NU-1] <= PW'(d[NU-1]);
            for (int i = 0; i < NU; i++) m[i] <= MW'(p[i]) * MW'(c[i]);
            acc <= acc_sum;
            v1  <= dv && !bus.clr;
            v2  <= v1 && !bus.clr;
            v3  <= v2 && !bus.clr;
        end
    end

    assign r = (RW'(acc) + RND) >>> SHIFT;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ov_q  <= 1'b0;
            sat_q <= 1'b0;
            y_q   <= '0;
        end else begin
            ov_q <= v3;
            if (v3) begin
                if (r > YMAX) begin
                    y_q   <= YMAX[DW-1:0];
                    sat_q <= 1'b1;
                end else if (r < YMIN) begin
                    y_q   <= YMIN[DW-1:0];
                    sat_q <= 1'b1;
                end else begin
                    y_q   <= r[DW-1:0];
                    sat_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.y         = y_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_fir_sym_pipe.sv
// Bench for fir_sym_pipe: SHIFT=0 and SHIFT=4 instances share stimulus and are
// checked every cycle against a convolution model plus fixed impulse responses.
module tb_fir_sym_pipe;
    localparam int DW = 16, CW = 16, NTAPS = 9, NU = 5, AW = 3;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    always #5 clk = ~clk;

    logic                 t_clr = 0, t_in_valid = 0, t_coef_we = 0;
    logic signed [DW-1:0] t_x = '0;
    logic [AW-1:0]        t_coef_addr = '0;
    logic signed [CW-1:0] t_coef_wdata = '0;

    fir_sym_pipe_if #(.DW(DW), .CW(CW), .AW(AW)) b0 ();
    fir_sym_pipe_if #(.DW(DW), .CW(CW), .AW(AW)) b1 ();

    assign b0.clr = t_clr;             assign b1.clr = t_clr;
    assign b0.in_valid = t_in_valid;   assign b1.in_valid = t_in_valid;
    assign b0.x = t_x;                 assign b1.x = t_x;
    assign b0.coef_we = t_coef_we;     assign b1.coef_we = t_coef_we;
    assign b0.coef_addr = t_coef_addr; assign b1.coef_addr = t_coef_addr;
    assign b0.coef_wdata = t_coef_wdata; assign b1.coef_wdata = t_coef_wdata;

    fir_sym_pipe #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(0)) u0 (.clk(clk), .rstN(rstN), .bus(b0.slave));
    fir_sym_pipe #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .SHIFT(4)) u1 (.clk(clk), .rstN(rstN), .bus(b1.slave));

    // reference model: window of accepted samples, pending products, expected accumulators
    int     win [NTAPS];
    int     coef [NU];
    int     n;
    int     pend_k [$];
    int     pend_w [$];
    int     exp_due [$];
    longint exp_acc [$];
    logic                 ev;
    logic signed [DW-1:0] ly0, ly1;
    logic                 ls0, ls1;
    int obs0 [$];
    int obs1 [$];
    int asserts = 0, fails = 0;

    int seq_def [9] = '{32, 18, 6, 0, -2, 0, 6, 18, 32};
    int seq_c8  [9] = '{32, 18, 6, 0, 8, 0, 6, 18, 32};
    int seq_mid [9] = '{32, 18, 6, 0, -2, 0, 6, 18, 100};
    int seq_r1  [9] = '{2, 1, 0, 0, 0, 0, 0, 1, 2};

    task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
        asserts++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic rnd_sat(longint acc, int sh, output logic signed [DW-1:0] yv, output logic s);
        longint rr;
        rr = acc;
        if (sh > 0) rr = rr + (longint'(1) << (sh - 1));
        rr = rr >>> sh;
        if (rr > 32767) begin yv = 16'sh7fff; s = 1'b1; end
        else if (rr < -32768) begin yv = 16'sh8000; s = 1'b1; end
        else begin yv = 16'(rr); s = 1'b0; end
    endtask

    task automatic model_edge();
        longint a;
        int h;
        if (t_clr) begin
            pend_k.delete();
            pend_w.delete();
            while (exp_due.size() > 0 && exp_due[$] > n) begin
                void'(exp_due.pop_back());
                void'(exp_acc.pop_back());
            end
            for (int t = 0; t < NTAPS; t++) win[t] = 0;
        end else begin
            // products for a sample are formed two edges after it was accepted
            if (pend_k.size() > 0 && pend_k[0] == n - 2) begin
                a = 0;
                for (int t = 0; t < NTAPS; t++) begin
                    h = (t < NU) ? t : NTAPS - 1 - t;
                    a += longint'(pend_w[t]) * longint'(coef[h]);
                end
                exp_due.push_back(n + 2);
                exp_acc.push_back(a);
                void'(pend_k.pop_front());
                for (int t = 0; t < NTAPS; t++) void'(pend_w.pop_front());
            end
            if (t_in_valid) begin
                for (int t = NTAPS - 1; t > 0; t--) win[t] = win[t-1];
                win[0] = t_x;
                pend_k.push_back(n);
                for (int t = 0; t < NTAPS; t++) pend_w.push_back(win[t]);
            end
        end
        if (t_coef_we && int'(t_coef_addr) < NU) coef[t_coef_addr] = t_coef_wdata;
        ev = (exp_due.size() > 0 && exp_due[0] == n);
        if (ev) begin
            rnd_sat(exp_acc[0], 0, ly0, ls0);
            rnd_sat(exp_acc[0], 4, ly1, ls1);
            void'(exp_due.pop_front());
            void'(exp_acc.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_edge();
        #1;
        chk("ov0", b0.out_valid, ev);
        chk("ov1", b1.out_valid, ev);
        chk("y0", b0.y, ly0);
        chk("y1", b1.y, ly1);
        chk("sat0", b0.sat, ls0);
        chk("sat1", b1.sat, ls1);
        if (b0.out_valid) obs0.push_back(int'(b0.y));
        if (b1.out_valid) obs1.push_back(int'(b1.y));
    endtask

    task automatic do_reset();
        #2 rstN = 1'b0;
        #1;
        chk("rst_y0", b0.y, 0);
        chk("rst_ov0", b0.out_valid, 0);
        chk("rst_sat0", b0.sat, 0);
        chk("rst_y1", b1.y, 0);
        chk("rst_ov1", b1.out_valid, 0);
        t_clr = 0; t_in_valid = 0; t_coef_we = 0; t_x = '0;
        for (int t = 0; t < NTAPS; t++) win[t] = 0;
        coef = '{32, 18, 6, 0, -2};
        pend_k.delete(); pend_w.delete(); exp_due.delete(); exp_acc.delete();
        ly0 = '0; ly1 = '0; ls0 = 0; ls1 = 0; ev = 0;
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
    endtask

    task automatic chk_seq(string tag, bit which, int expv [9]);
        int v;
        for (int i = 0; i < 9; i++) begin
            if (which) v = (i < obs1.size()) ? obs1[i] : -99999;
            else       v = (i < obs0.size()) ? obs0[i] : -99999;
            chk($sformatf("%s[%0d]", tag, i), v, expv[i]);
        end
    endtask

    task automatic impulse(int amp, bit gap);
        obs0.delete(); obs1.delete();
        t_in_valid = 1; t_x = 16'(amp); step();
        for (int i = 0; i < 11; i++) begin
            if (gap) begin t_in_valid = 0; t_x = 16'sh1234; step(); end
            t_in_valid = 1; t_x = '0; step();
        end
        t_in_valid = 0;
        repeat (6) step();
    endtask

    task automatic hold_x(int v, int cnt);
        t_in_valid = 1; t_x = 16'(v);
        repeat (cnt) step();
    endtask

    initial begin
        n = 0;
        do_reset();

        impulse(1, 0);                       // defaults, both shifts
        chk_seq("imp_s0", 0, seq_def);
        chk_seq("imp_s4", 1, seq_r1);
        chk("imp_tail", obs0.size() > 9 ? obs0[9] : -99999, 0);

        impulse(16, 0);
        chk_seq("imp16_s4", 1, seq_def);

        impulse(1, 1);                       // gapped input
        chk_seq("gap_s0", 0, seq_def);

        t_coef_we = 1; t_coef_addr = 3'd4; t_coef_wdata = 16'sd8; step();
        t_coef_addr = 3'd7; t_coef_wdata = 16'sd999; step();
        t_coef_we = 0;
        impulse(1, 0);
        chk_seq("c4w", 0, seq_c8);

        do_reset();                          // mid-impulse write to c0
        obs0.delete(); obs1.delete();
        t_in_valid = 1; t_x = 16'sd1; step();
        for (int i = 1; i <= 12; i++) begin
            t_x = '0; t_coef_we = (i == 4); t_coef_addr = 3'd0; t_coef_wdata = 16'sd100;
            step();
        end
        t_coef_we = 0; t_in_valid = 0;
        repeat (4) step();
        chk_seq("midw", 0, seq_mid);

        do_reset();                          // saturation
        hold_x(32767, 14);
        chk("sat_hi_y", b0.y, 32767);
        chk("sat_hi_s", b0.sat, 1);
        hold_x(-32768, 14);
        chk("sat_lo_y", b0.y, -32768);
        chk("sat_lo_s", b0.sat, 1);
        hold_x(10, 14);
        chk("small_y", b0.y, 1100);
        chk("small_s", b0.sat, 0);
        hold_x(0, 12);
        t_in_valid = 0; repeat (5) step();

        t_in_valid = 1; t_x = 16'sd1; step();    // clr two cycles into an impulse
        t_x = '0; step();
        t_in_valid = 1; t_x = 16'sd500; t_clr = 1; step();
        t_clr = 0; t_in_valid = 0;
        repeat (8) step();
        impulse(1, 0);
        chk_seq("post_clr", 0, seq_def);

        t_coef_we = 1; t_coef_addr = 3'd4; t_coef_wdata = 16'sd77; step();
        t_coef_we = 0;
        hold_x(300, 6);
        do_reset();                          // reset mid-stream restores c4
        repeat (8) step();
        impulse(1, 0);
        chk_seq("post_rst", 0, seq_def);

        for (int i = 0; i < 400; i++) begin
            t_in_valid   = ($urandom_range(0, 3) != 0);
            t_x          = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 400) - 200);
            t_clr        = ($urandom_range(0, 39) == 0);
            t_coef_we    = ($urandom_range(0, 15) == 0);
            t_coef_addr  = 3'($urandom_range(0, 7));
            t_coef_wdata = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
            step();
            if (i == 250) do_reset();
        end
        t_in_valid = 0; t_clr = 0; t_coef_we = 0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
